// File: rtl/mul_div_if.sv
// Operand/result bundle between the control path and the iterative multiply/divide unit.
// The master side drives requests and MTHI/MTLO writes; the slave side returns status and HI/LO.
interface mul_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            hilo_we;
    logic            hilo_sel;
    logic [XLEN-1:0] hilo_wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hilo_we, hilo_sel, hilo_wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hilo_we, hilo_sel, hilo_wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO. Signed operations run on
// magnitudes and the result sign is fixed up in a single cycle after the last step.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    mul_div_if.slave    bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_divz;
    logic [XLEN-1:0]   r_a_raw;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_busy;
    logic              r_done;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN+1:0]   w_div_trial;
    logic [2*XLEN-1:0] w_p_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res_hi;
    logic [XLEN-1:0]   w_res_lo;

    // op[0]=0 selects the signed variants (MULT/DIV)
    assign w_a_neg = ~bus.op[0] & bus.operand_a[XLEN-1];
    assign w_b_neg = ~bus.op[0] & bus.operand_b[XLEN-1];
    assign w_a_mag = w_a_neg ? ({XLEN{1'b0}} - bus.operand_a) : bus.operand_a;
    assign w_b_mag = w_b_neg ? ({XLEN{1'b0}} - bus.operand_b) : bus.operand_b;

    // r_p holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_mul_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_div_shift = r_p[2*XLEN-1:XLEN-1];
    assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_b};

    // Next iteration value for the shared shift register
    always_comb begin
        w_p_next = r_p;
        if (r_is_div) begin
            if (!w_div_trial[XLEN+1]) begin
                w_p_next = {w_div_trial[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
            end else begin
                w_p_next = {w_div_shift[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
            end
        end else begin
            w_p_next = {w_mul_sum, r_p[XLEN-1:1]};
        end
    end

    assign w_prod = r_neg_q ? ({(2*XLEN){1'b0}} - r_p) : r_p;
    assign w_quo  = r_neg_q ? ({XLEN{1'b0}} - r_p[XLEN-1:0]) : r_p[XLEN-1:0];
    assign w_rem  = r_neg_r ? ({XLEN{1'b0}} - r_p[2*XLEN-1:XLEN]) : r_p[2*XLEN-1:XLEN];

    // Final HI/LO selection, including the divide-by-zero convention
    always_comb begin
        w_res_hi = w_prod[2*XLEN-1:XLEN];
        w_res_lo = w_prod[XLEN-1:0];
        if (r_is_div) begin
            if (r_divz) begin
                w_res_hi = r_a_raw;
                w_res_lo = {XLEN{1'b1}};
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end else begin
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end
    end

    // Control FSM, datapath registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_a_raw  <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_p      <= {(2*XLEN){1'b0}};
            r_hi     <= {XLEN{1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_CALC;
                        r_cnt    <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_divz   <= (bus.operand_b == {XLEN{1'b0}});
                        r_a_raw  <= bus.operand_a;
                        if (bus.op[1]) begin
                            r_b <= w_b_mag;
                            r_p <= {{XLEN{1'b0}}, w_a_mag};
                        end else begin
                            r_b <= w_a_mag;
                            r_p <= {{XLEN{1'b0}}, w_b_mag};
                        end
                    end else if (bus.hilo_we) begin
                        if (bus.hilo_sel) begin
                            r_hi <= bus.hilo_wdata;
                        end else begin
                            r_lo <= bus.hilo_wdata;
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO registers.
- Sits directly downstream of the GPR file: operands come from the read ports `reg_A`/`reg_B`.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. The control path stalls on `busy`.
- Also services MTHI/MTLO writes. HI/LO are read combinationally for MFHI/MFLO.

Parameters:
- XLEN, 32, operand and HI/LO width; the iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an operation; sampled only when busy=0
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  XLEN  rs value (from reg_A); multiplicand or dividend
- operand_b  input  XLEN  rt value (from reg_B); multiplier or divisor
- hilo_we  input  1  MTHI/MTLO write strobe
- hilo_sel  input  1  target of the write: 0 = LO, 1 = HI
- hilo_wdata  input  XLEN  data for MTHI/MTLO
- busy  output  1  operation in progress; stall MFHI/MFLO, new mult/div and MTHI/MTLO
- done  output  1  one-cycle pulse: HI/LO updated with the result
- hi  output  XLEN  HI register (MFHI source)
- lo  output  XLEN  LO register (MFLO source)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; hi=0, lo=0, busy=0, done=0; the iteration counter clears. Reset has priority over every other input, including mid-operation: the operation aborts and no partial result is written.
- States and transitions:
  - IDLE: start=1 latches op and operands into internal registers, counter=0, next state CALC.
  - CALC: one radix-2 step per cycle. After XLEN steps, next state FIX.
  - FIX: sign correction, write HI/LO, done=1, next state IDLE.
- Timing:
  - Start sampled at edge N: busy=1 after edges N..N+32.
  - Edge N+33: hi/lo take the result, done=1 for exactly one cycle, busy=0.
  - A new start may be sampled at edge N+34.
  - done=0 at all other times.
- Operands are captured at the start edge. Later changes on operand_a/operand_b/op have no effect.
- start while busy=1 is ignored; there is no queuing.
- hilo_we:
  - In IDLE without start, hilo_we writes hilo_wdata to HI (sel=1) or LO (sel=0) at the edge. The other register is unchanged.
  - hilo_we while busy=1 is ignored.
  - start and hilo_we at the same IDLE edge: start wins and the write is dropped.
- Multiply:
  - The 64-bit product gives {hi, lo}.
  - MULTU: unsigned shift-add on the 32-bit operands.
  - MULT: operate on magnitudes, then negate the 64-bit product in FIX if the operand signs differ.
- Divide: restoring division on magnitudes. lo = quotient, hi = remainder.
  - DIVU: unsigned.
  - DIV: quotient truncates toward zero; its sign is negative iff the operand signs differ. The remainder takes the sign of the dividend.
- Divide by zero (operand_b=0), both DIV and DIVU: full latency still applies. Result hi=operand_a, lo=32'hFFFFFFFF.
- DIV with 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
- hi and lo outputs hold their values during CALC. They change only at reset, at a hilo_we write, or at the FIX edge.

Test Plan:
1. Reset, then MULTU: a=32'hFFFFFFFF, b=32'hFFFFFFFF, start at edge N -> busy=1 for 33 cycles; done pulse after edge N+33; hi=32'hFFFFFFFE, lo=32'h00000001.
2. Signed multiply and divide in sequence:
   - MULT a=-3 (32'hFFFFFFFD), b=7 -> {hi,lo}=-21: hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
   - Then DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
3. Divide corner cases:
   - DIVU a=100, b=0 -> hi=100, lo=32'hFFFFFFFF after full latency.
   - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
4. Busy-time interference: during a DIVU 17/5, pulse start with MULTU 2*3, pulse hilo_we sel=1 data=32'hDEAD, and change operand_a -> all ignored; final hi=2, lo=3; exactly one done pulse.
5. MTHI/MTLO in IDLE and collision:
   - hilo_we sel=0 data=32'h1234 -> lo=32'h1234, hi unchanged.
   - Same edge start (MULTU 4*5) and hilo_we -> write dropped; result lo=20, hi=0.
6. Reset mid-operation: assert rst for one cycle at iteration 10 of a MULTU -> hi=0, lo=0, busy=0; no done pulse; next start completes normally in 33 cycles.
